dmem_responder: RTL

- Handshaked data-memory responder: the target side of the load/store requests issued by the pipeline's memory stage.
- Accepts one request at a time and applies a configurable access latency. Returns read data, or a store acknowledge, on a valid/ready response channel.
- Supports RV32I byte, half and word accesses, selected by func3. Loads are sign- or zero-extended.
- The pipeline holds its M stage while a request is outstanding.

---
 rtl/dmem_responder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory target for the M stage.
// Accepts one load/store at a time. The access happens on the edge that
// enters RESP, LATENCY cycles after acceptance. The result is held on a
// valid/ready response channel until the consumer takes it.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state;
    logic [3:0]       count;

    logic             weQ;
    logic [2:0]       func3Q;
    logic [IDX_W+1:0] addrQ;
    logic [31:0]      wdataQ;

    logic             accept;
    logic             enterResp;

    logic             accWe;
    logic [2:0]       accFunc3;
    logic [IDX_W+1:0] accAddr;
    logic [31:0]      accWdata;

    logic [IDX_W-1:0] wordIdx;
    logic [1:0]       lane;
    logic             accErr;
    logic [31:0]      curWord;
    logic [7:0]       selByte;
    logic [15:0]      selHalf;
    logic [31:0]      loadData;
    logic [31:0]      mergedWord;

    logic             addrHiUnused;

    logic [31:0]      mem [DEPTH_WORDS];

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);

    assign accept = (state == ST_IDLE) && req_valid;

    // With LATENCY==1 the accepting edge is also the access edge.
    assign enterResp = (LATENCY == 1) ? accept
                                      : ((state == ST_WAIT) && (count == 4'd1));

    assign addrHiUnused = ^req_addr[31:IDX_W+2];

    // The access uses the live request when it happens on the accepting edge,
    // and the captured request otherwise.
    always_comb begin
        if (state == ST_IDLE) begin
            accWe    = req_we;
            accFunc3 = req_func3;
            accAddr  = req_addr[IDX_W+1:0];
            accWdata = req_wdata;
        end else begin
            accWe    = weQ;
            accFunc3 = func3Q;
            accAddr  = addrQ;
            accWdata = wdataQ;
        end
    end

    assign wordIdx = accAddr[IDX_W+1:2];
    assign lane    = accAddr[1:0];
    assign curWord = mem[wordIdx];

    // Flag illegal func3 encodings and misaligned half/word accesses.
    always_comb begin
        accErr = 1'b0;
        case (accFunc3)
            3'b000, 3'b100: accErr = accWe && accFunc3[2];
            3'b001, 3'b101: accErr = lane[0] || (accWe && accFunc3[2]);
            3'b010:         accErr = (lane != 2'b00);
            default:        accErr = 1'b1;
        endcase
    end

    // Select the addressed byte/half and extend it to 32 bits for loads.
    always_comb begin
        selByte = curWord[7:0];
        case (lane)
            2'd0:    selByte = curWord[7:0];
            2'd1:    selByte = curWord[15:8];
            2'd2:    selByte = curWord[23:16];
            default: selByte = curWord[31:24];
        endcase
        selHalf = lane[1] ? curWord[31:16] : curWord[15:0];
        case (accFunc3[1:0])
            2'b00:   loadData = {{24{selByte[7] & ~accFunc3[2]}}, selByte};
            2'b01:   loadData = {{16{selHalf[15] & ~accFunc3[2]}}, selHalf};
            default: loadData = curWord;
        endcase
    end

    // Merge store data into the addressed lanes, leaving the others intact.
    always_comb begin
        mergedWord = curWord;
        case (accFunc3[1:0])
            2'b00: begin
                case (lane)
                    2'd0:    mergedWord[7:0]   = accWdata[7:0];
                    2'd1:    mergedWord[15:8]  = accWdata[7:0];
                    2'd2:    mergedWord[23:16] = accWdata[7:0];
                    default: mergedWord[31:24] = accWdata[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    mergedWord[31:16] = accWdata[15:0];
                end else begin
                    mergedWord[15:0] = accWdata[15:0];
                end
            end
            default: mergedWord = accWdata;
        endcase
    end

    // Array write on RESP entry; reset on that same edge aborts the access.
    always_ff @(posedge clk) begin
        if (!rst && enterResp && accWe && !accErr) begin
            mem[wordIdx] <= mergedWord;
        end
    end

    // Request capture, latency countdown and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        weQ    <= req_we;
                        func3Q <= req_func3;
                        addrQ  <= req_addr[IDX_W+1:0];
                        wdataQ <= req_wdata;
                        if (LATENCY == 1) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            count <= LAT_M1;
                        end
                    end
                end
                ST_WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (enterResp) begin
                resp_rdata <= (accWe || accErr) ? '0 : loadData;
                resp_err   <= accErr;
            end
        end
    end

endmodule
